// File: rtl/noc_rr_switch_alloc.sv
// Round-robin switch allocator with registered valid/ready output slots for the 3-port NoC router.
// Each output picks one requesting input per cycle. Malformed head flits are popped and counted.
module noc_rr_switch_alloc #(
  parameter int DW    = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             emptyE,
  input  logic             emptyW,
  input  logic             emptyL,
  input  logic [DW-1:0]    headE,
  input  logic [DW-1:0]    headW,
  input  logic [DW-1:0]    headL,
  output logic             popE,
  output logic             popW,
  output logic             popL,
  input  logic             out_readyE,
  input  logic             out_readyW,
  input  logic             out_readyL,
  output logic             out_validE,
  output logic             out_validW,
  output logic             out_validL,
  output logic [DW-1:0]    out_dataE,
  output logic [DW-1:0]    out_dataW,
  output logic [DW-1:0]    out_dataL,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int NP = 3;

  logic [NP-1:0]    empty;
  logic [NP-1:0]    ready;
  logic [NP-1:0]    req;
  logic [NP-1:0]    drop;
  logic [NP-1:0]    pop;
  logic [NP-1:0]    gnt_vld;
  logic [NP-1:0]    out_valid;
  logic [DW-1:0]    head     [NP];
  logic [1:0]       dest     [NP];
  logic [1:0]       gnt_idx  [NP];
  logic [DW-1:0]    out_data [NP];
  logic [CNT_W-1:0] drop_cnt_reg;
  logic [CNT_W-1:0] drop_cnt_next;
  logic [CNT_W+1:0] drop_sum;

  assign empty   = {emptyL, emptyW, emptyE};
  assign ready   = {out_readyL, out_readyW, out_readyE};
  assign head[0] = headE;
  assign head[1] = headW;
  assign head[2] = headL;

  // Index k steps after p, wrapping over the three ports.
  function automatic logic [1:0] rr_next(input logic [1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NP;
    return s[1:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_in
      assign dest[gi] = head[gi][2:1];
      assign req[gi]  = !empty[gi] && head[gi][0] && (head[gi][2:1] != 2'b11);
      assign drop[gi] = !empty[gi] && !req[gi];
    end

    for (gi = 0; gi < NP; gi++) begin : g_out
      logic          free;
      logic          g_vld;
      logic [1:0]    g_idx;
      logic          valid_reg;
      logic [DW-1:0] data_reg;
      logic [1:0]    ptr_reg;

      assign free = !valid_reg || ready[gi];

      // Search starts just after the last winner, so the last winner is tried last.
      always_comb begin
        logic [1:0] cand;
        g_vld = 1'b0;
        g_idx = 2'd0;
        cand  = 2'd0;
        for (int k = 1; k <= NP; k++) begin
          cand = rr_next(ptr_reg, k);
          if (!g_vld && free && req[cand] && dest[cand] == 2'(gi)) begin
            g_vld = 1'b1;
            g_idx = cand;
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
          ptr_reg   <= 2'd2;
        end else if (g_vld) begin
          valid_reg <= 1'b1;
          data_reg  <= head[g_idx];
          ptr_reg   <= g_idx;
        end else if (ready[gi]) begin
          valid_reg <= 1'b0;
        end
      end

      assign gnt_vld[gi]  = g_vld;
      assign gnt_idx[gi]  = g_idx;
      assign out_valid[gi] = valid_reg;
      assign out_data[gi]  = data_reg;
    end
  endgenerate

  always_comb begin
    pop = drop;
    for (int i = 0; i < NP; i++) begin
      for (int o = 0; o < NP; o++) begin
        if (gnt_vld[o] && gnt_idx[o] == 2'(i)) pop[i] = 1'b1;
      end
    end
    pop = pop & {NP{!reset}};
  end

  always_comb begin
    drop_sum = {2'b00, drop_cnt_reg};
    for (int i = 0; i < NP; i++) drop_sum = drop_sum + (CNT_W+2)'(drop[i]);
    if (drop_sum > {2'b00, {CNT_W{1'b1}}}) drop_cnt_next = {CNT_W{1'b1}};
    else drop_cnt_next = drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_reg <= '0;
    else drop_cnt_reg <= drop_cnt_next;
  end

  assign popE       = pop[0];
  assign popW       = pop[1];
  assign popL       = pop[2];
  assign out_validE = out_valid[0];
  assign out_validW = out_valid[1];
  assign out_validL = out_valid[2];
  assign out_dataE  = out_data[0];
  assign out_dataW  = out_data[1];
  assign out_dataL  = out_data[2];
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_noc_rr_switch_alloc.sv
// Bench for noc_rr_switch_alloc: directed vector table, hand sequences for stall/fairness/reset/saturation,
// then random traffic against a round-robin reference model.
module tb_noc_rr_switch_alloc;
  localparam int DW = 16;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic emptyE, emptyW, emptyL;
  logic [DW-1:0] headE, headW, headL;
  logic popE, popW, popL;
  logic out_readyE, out_readyW, out_readyL;
  logic out_validE, out_validW, out_validL;
  logic [DW-1:0] out_dataE, out_dataW, out_dataL;
  logic [CNT_W-1:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  noc_rr_switch_alloc #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .emptyE(emptyE), .emptyW(emptyW), .emptyL(emptyL),
    .headE(headE), .headW(headW), .headL(headL),
    .popE(popE), .popW(popW), .popL(popL),
    .out_readyE(out_readyE), .out_readyW(out_readyW), .out_readyL(out_readyL),
    .out_validE(out_validE), .out_validW(out_validW), .out_validL(out_validL),
    .out_dataE(out_dataE), .out_dataW(out_dataW), .out_dataL(out_dataL),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  empty;  // {L,W,E}
    logic [15:0] he, hw, hl;
    logic [2:0]  pops;   // {L,W,E}
    logic [2:0]  vld;    // {L,W,E}
    logic [15:0] de, dw, dl;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl [8];

  // reference model state
  int           m_ptr  [3];
  logic         m_vld  [3];
  logic [15:0]  m_data [3];
  int           m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] pops();
    return {popL, popW, popE};
  endfunction

  function automatic logic [2:0] vlds();
    return {out_validL, out_validW, out_validE};
  endfunction

  function automatic logic [DW-1:0] dut_data(input int o);
    case (o)
      0: return out_dataE;
      1: return out_dataW;
      default: return out_dataL;
    endcase
  endfunction

  task automatic drive(input logic [2:0] e, input logic [15:0] he, input logic [15:0] hw,
                       input logic [15:0] hl, input logic [2:0] r);
    {emptyL, emptyW, emptyE} = e;
    headE = he;
    headW = hw;
    headL = hl;
    {out_readyL, out_readyW, out_readyE} = r;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    after_edge();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] hs [3];
    logic [15:0] exp_d;

    tbl[0] = '{3'b110, 16'h0003, 16'h0000, 16'h0000, 3'b001, 3'b010, 16'h0, 16'h0003, 16'h0, 8'd0};
    tbl[1] = '{3'b000, 16'h0003, 16'h0001, 16'h0005, 3'b111, 3'b111, 16'h0001, 16'h0003, 16'h0005, 8'd0};
    tbl[2] = '{3'b011, 16'h0000, 16'h0000, 16'h0007, 3'b100, 3'b000, 16'h0, 16'h0, 16'h0, 8'd1};
    tbl[3] = '{3'b011, 16'h0000, 16'h0000, 16'h0002, 3'b100, 3'b000, 16'h0, 16'h0, 16'h0, 8'd2};
    tbl[4] = '{3'b111, 16'h0003, 16'h0003, 16'h0003, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 8'd2};
    tbl[5] = '{3'b100, 16'h0105, 16'h0205, 16'h0000, 3'b001, 3'b100, 16'h0, 16'h0, 16'h0105, 8'd2};
    tbl[6] = '{3'b100, 16'h0105, 16'h0205, 16'h0000, 3'b010, 3'b100, 16'h0, 16'h0, 16'h0205, 8'd2};
    tbl[7] = '{3'b000, 16'h0105, 16'h0205, 16'h0405, 3'b100, 3'b100, 16'h0, 16'h0, 16'h0405, 8'd2};

    // reset state, with inputs that would otherwise pop
    drive(3'b000, 16'h0003, 16'h0002, 16'h0007, 3'b111);
    after_edge();
    after_edge();
    chk("rst_pop", 32'(pops()), 32'd0);
    chk("rst_valid", 32'(vlds()), 32'd0);
    chk("rst_dataE", 32'(out_dataE), 32'd0);
    chk("rst_dataL", 32'(out_dataL), 32'd0);
    chk("rst_cnt", 32'(drop_cnt), 32'd0);
    reset = 1'b0;

    // directed vector table, all outputs ready
    for (int k = 0; k < 8; k++) begin
      drive(tbl[k].empty, tbl[k].he, tbl[k].hw, tbl[k].hl, 3'b111);
      @(negedge clk);
      chk("tbl_pop", 32'(pops()), 32'(tbl[k].pops));
      after_edge();
      chk("tbl_valid", 32'(vlds()), 32'(tbl[k].vld));
      if (tbl[k].vld[0]) chk("tbl_dataE", 32'(out_dataE), 32'(tbl[k].de));
      if (tbl[k].vld[1]) chk("tbl_dataW", 32'(out_dataW), 32'(tbl[k].dw));
      if (tbl[k].vld[2]) chk("tbl_dataL", 32'(out_dataL), 32'(tbl[k].dl));
      chk("tbl_cnt", 32'(drop_cnt), 32'(tbl[k].cnt));
      $display("vector %0d pops=%b valid=%b cnt=%0d", k, pops(), vlds(), drop_cnt);
    end

    // stall: E output held while W keeps requesting East
    drive(3'b101, 16'h0000, 16'h0011, 16'h0000, 3'b110);
    @(negedge clk);
    chk("stall_load_pop", 32'(pops()), 32'b010);
    after_edge();
    chk("stall_load_dataE", 32'(out_dataE), 32'h0011);
    drive(3'b101, 16'h0000, 16'h0021, 16'h0000, 3'b110);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_pop", 32'(pops()), 32'd0);
      after_edge();
      chk("stall_validE", 32'(out_validE), 32'd1);
      chk("stall_dataE", 32'(out_dataE), 32'h0011);
    end
    out_readyE = 1'b1;
    @(negedge clk);
    chk("unstall_pop", 32'(pops()), 32'b010);
    after_edge();
    chk("unstall_dataE", 32'(out_dataE), 32'h0021);
    chk("unstall_validE", 32'(out_validE), 32'd1);
    drive(3'b111, 16'h0000, 16'h0000, 16'h0000, 3'b111);
    after_edge();
    chk("drain_validE", 32'(out_validE), 32'd0);
    chk("drain_dataE_kept", 32'(out_dataE), 32'h0021);
    $display("stall sequence done");

    // saturation: 300 consecutive illegal-dest flits on L
    drive(3'b011, 16'h0000, 16'h0000, 16'h0007, 3'b111);
    @(negedge clk);
    chk("sat_pop", 32'(pops()), 32'b100);
    for (int n = 0; n < 300; n++) begin
      after_edge();
      if (n == 99) chk("sat_cnt_mid", 32'(drop_cnt), 32'd102);
    end
    chk("sat_cnt", 32'(drop_cnt), 32'hFF);
    chk("sat_valid", 32'(vlds()), 32'd0);
    $display("saturation done cnt=%0h", drop_cnt);

    // fairness on Local, then reset mid-stream
    hs[0] = 16'h0105;
    hs[1] = 16'h0205;
    hs[2] = 16'h0405;
    drive(3'b000, hs[0], hs[1], hs[2], 3'b111);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk("rr_pop", 32'(pops()), 32'(3'b001 << (s % 3)));
      after_edge();
      exp_d = hs[s % 3];
      chk("rr_dataL", 32'(out_dataL), 32'(exp_d));
      chk("rr_validL", 32'(out_validL), 32'd1);
      $display("rr step %0d dataL=%h", s, out_dataL);
    end
    chk("rr_cnt_held", 32'(drop_cnt), 32'hFF);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pop", 32'(pops()), 32'd0);
    chk("arst_valid", 32'(vlds()), 32'd0);
    chk("arst_dataL", 32'(out_dataL), 32'd0);
    chk("arst_cnt", 32'(drop_cnt), 32'd0);
    after_edge();
    chk("arst_pop_held", 32'(pops()), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_pop", 32'(pops()), 32'b001);
    after_edge();
    chk("post_rst_dataL", 32'(out_dataL), 32'h0105);
    @(negedge clk);
    chk("post_rst_pop2", 32'(pops()), 32'b010);
    $display("reset-in-stream sequence done");

    // random traffic against the reference model
    after_edge();
    do_reset();
    for (int o = 0; o < 3; o++) begin
      m_ptr[o] = 2;
      m_vld[o] = 1'b0;
      m_data[o] = '0;
    end
    m_cnt = 0;
    for (int n = 0; n < 1500; n++) begin
      logic [2:0]  e, r, exp_pop;
      logic [15:0] h [3];
      int          gsel [3];
      int          ndrop, best, d;
      for (int i = 0; i < 3; i++) begin
        e[i] = ($urandom_range(0, 3) == 0);
        h[i] = 16'($urandom);
        h[i][0] = ($urandom_range(0, 9) != 0);
        r[i] = ($urandom_range(0, 9) < 7);
      end
      drive(e, h[0], h[1], h[2], r);
      exp_pop = '0;
      ndrop = 0;
      for (int i = 0; i < 3; i++) begin
        if (!e[i] && (!h[i][0] || h[i][2:1] == 2'b11)) begin
          exp_pop[i] = 1'b1;
          ndrop++;
        end
      end
      for (int o = 0; o < 3; o++) begin
        gsel[o] = -1;
        if (!m_vld[o] || r[o]) begin
          best = 3;
          for (int i = 0; i < 3; i++) begin
            if (!e[i] && h[i][0] && int'(h[i][2:1]) == o) begin
              d = (i - m_ptr[o] + 5) % 3;  // 0 for ptr+1, 2 for ptr itself
              if (d < best) begin
                best = d;
                gsel[o] = i;
              end
            end
          end
        end
        if (gsel[o] >= 0) exp_pop[gsel[o]] = 1'b1;
      end
      @(negedge clk);
      chk("rnd_pop", 32'(pops()), 32'(exp_pop));
      for (int o = 0; o < 3; o++) begin
        if (gsel[o] >= 0) begin
          m_vld[o] = 1'b1;
          m_data[o] = h[gsel[o]];
          m_ptr[o] = gsel[o];
        end else if (r[o]) begin
          m_vld[o] = 1'b0;
        end
      end
      m_cnt = (m_cnt + ndrop > 255) ? 255 : m_cnt + ndrop;
      after_edge();
      for (int o = 0; o < 3; o++) begin
        chk("rnd_valid", 32'(vlds() >> o) & 32'd1, 32'(m_vld[o]));
        chk("rnd_data", 32'(dut_data(o)), 32'(m_data[o]));
      end
      chk("rnd_cnt", 32'(drop_cnt), 32'(m_cnt));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
